ray_plane_t: RTL and testbench
==============================

// Module: ray_plane_t
// PURPOSE
//  Upstream feeder for the iterative signed divider (div). Accepts one ray/plane pair, computes
//  num = pl_d - N.O and den = N.D in Q16.16 with one shared multiplier, then drives div to get
//  t = num/den. Returns t with a hit flag to the intersection/shading stage.
//  Sits between the ray generator and the closest-hit compare stage of the ray tracer.
// PARAMETERS
//  W      32  data width of every scalar (signed fixed point)
//  FRAC   16  fraction bits; div instantiated internally with DWIDTH = W+FRAC, FAST = 1
//  T_MIN  32'sh0000_0040  smallest t reported as hit (self-intersection guard)
// PORTS
//  clock      in   1     clock
//  reset      in   1     reset, asynchronous, active-high
//  in_valid   in   1     request valid
//  in_ready   out  1     block idle, request accepted when in_valid & in_ready
//  ray_o      in   3*W   ray origin {z,y,x}, signed QW-FRAC.FRAC
//  ray_d      in   3*W   ray direction {z,y,x}
//  pl_n       in   3*W   plane normal {z,y,x}
//  pl_d       in   W     plane offset (N.P = pl_d)
//  out_valid  out  1     result valid, held until out_ready
//  out_ready  in   1     consumer accepts result
//  t          out  W     ray parameter, signed Q16.16, saturated
//  hit        out  1     1 = den != 0 and t >= T_MIN
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, t=0, hit=0, state IDLE, div held in reset by same reset.
//  Inputs captured into regs on accept; inputs may change afterwards.
//  FSM: IDLE -> DOT -> CHECK -> DSTART -> DWAIT -> OUT -> IDLE; CHECK -> OUT when den == 0.
//  IDLE: in_ready=1; on accept go DOT, in_ready drops next cycle.
//  DOT: 6 cycles, one product/cycle: nx*dx, ny*dy, nz*dz, nx*ox, ny*oy, nz*oz.
//   Product 2W bits, arithmetic shift right FRAC (truncate toward -inf), accumulate in W+2 bits.
//  CHECK: num = pl_d - acc_no; num and den saturated to [-(2^(W-1)-1), 2^(W-1)-1]
//   (symmetric, so div negation never overflows). den == 0 -> t=0, hit=0, go OUT, no div start.
//  DSTART: start=1 for exactly one cycle; dividend = num <<< FRAC (W+FRAC bits),
//   divisor = sign-extended den. Dividend/divisor held stable from DSTART until OUT
//   (div quotient sign is combinational on its inputs).
//  DWAIT: wait for div done=1 (stale done cleared at the start edge, never seen here).
//   On done: t = quotient saturated to W bits (>2^(W-1)-1 -> 0x7FFF_FFFF, <-2^(W-1) -> 0x8000_0000);
//   hit = (t >= T_MIN). Go OUT.
//  OUT: out_valid=1, t/hit stable; on out_ready go IDLE (out_valid=0 next cycle). No bypass:
//   in_ready stays 0 in OUT even if out_ready=1 the same cycle.
//  Latency accept->out_valid: 8 + div cycles (den != 0); 8 cycles (den == 0).
//  Quotient truncates toward zero (div semantics); num == 0 gives t=0, hit=0.
//  Reset mid-operation: any state returns to IDLE immediately, pending result discarded.
//  One transaction in flight; throughput bounded by divider iterations.
// TESTING
//  O=0, D=(0,0,0x10000), N=(0,0,0x10000), pl_d=0x50000 -> t=0x0005_0000, hit=1.
//  N=(0,0,0xFFFF_0000), D=(0,0,0x10000), O=0, pl_d=0x0002_8000 -> num=2.5, den=-1.0 ->
//   t=0xFFFD_8000, hit=0; then pl_d=0xFFFD_8000 -> t=0x0002_8000, hit=1.
//  D=(0x10000,0,0), N=(0,0,0x10000) -> den=0: no div start seen, t=0, hit=0, out_valid at cycle 8.
//  pl_d=0x7FFF_0000, den=0x0000_0001 -> t=0x7FFF_FFFF (saturated), hit=1.
//  Hold out_ready=0 for 20 cycles in OUT -> t/hit/out_valid stable, in_ready=0, next request
//   accepted only after the out_ready handshake.
//  Assert reset during DWAIT -> out_valid=0, in_ready=1 after release; next request (case 1)
//   returns t=0x0005_0000, hit=1.

Source files
------------

// File: rtl/ray_plane_t.sv
`default_nettype none
// ============================================================================
//  Module   : ray_plane_t (with internal iterative divider div)
//  Purpose  : Ray/plane intersection front end. Computes
//             num = pl_d - N.O and den = N.D (signed Q16.16) using a single
//             shared multiplier, then runs an iterative signed divider to
//             produce t = num/den with a hit flag (den != 0 and t >= T_MIN).
//  Ports    : clock, reset (async, active-high)
//             in_valid/in_ready   : request handshake
//             ray_o, ray_d, pl_n  : 3-vectors {z,y,x}, W bits per component
//             pl_d                : plane offset
//             out_valid/out_ready : result handshake, result held until taken
//             t, hit              : saturated ray parameter and hit flag
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  div : iterative restoring signed divider, quotient truncates toward zero.
//  Magnitudes are divided; the quotient sign is taken combinationally from the
//  operand sign bits, so the operands must stay stable until done is consumed.
//  FAST != 0 retires two quotient bits per clock instead of one.
// ----------------------------------------------------------------------------
module div #(
    parameter int DWIDTH = 48,
    parameter int FAST   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic [DWIDTH-1:0] quotient,
    output logic              done
);
    localparam int STEPS = (FAST != 0) ? 2 : 1;
    localparam int ITER  = DWIDTH / STEPS;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [DWIDTH-1:0] r_q;      // dividend bits shift out, quotient bits shift in
    logic [DWIDTH:0]   r_rem;
    logic [DWIDTH-1:0] r_dabs;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    logic [DWIDTH-1:0] w_dvd_abs;
    logic [DWIDTH-1:0] w_dvs_abs;
    logic              w_neg;
    logic [DWIDTH-1:0] w_q;
    logic [DWIDTH:0]   w_rem;

    assign w_dvd_abs = dividend[DWIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_dvs_abs = divisor[DWIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_neg     = dividend[DWIDTH-1] ^ divisor[DWIDTH-1];
    assign quotient  = w_neg ? (~r_q + 1'b1) : r_q;

    always_comb begin
        w_rem = r_rem;
        w_q   = r_q;
        for (int s = 0; s < STEPS; s++) begin
            w_rem = {w_rem[DWIDTH-1:0], w_q[DWIDTH-1]};
            w_q   = {w_q[DWIDTH-2:0], 1'b0};
            if (w_rem >= {1'b0, r_dabs}) begin
                w_rem  = w_rem - {1'b0, r_dabs};
                w_q[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dabs <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            r_q    <= w_dvd_abs;
            r_rem  <= '0;
            r_dabs <= w_dvs_abs;
            r_cnt  <= CNT_W'(ITER);
            r_busy <= 1'b1;
            done   <= 1'b0;
        end else if (r_busy) begin
            r_q   <= w_q;
            r_rem <= w_rem;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                done   <= 1'b1;
            end
        end
    end
endmodule

// ----------------------------------------------------------------------------
//  ray_plane_t : top level
// ----------------------------------------------------------------------------
module ray_plane_t #(
    parameter int                    W     = 32,
    parameter int                    FRAC  = 16,
    parameter logic signed [W-1:0]   T_MIN = 32'sh0000_0040
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*W-1:0] ray_o,
    input  logic [3*W-1:0] ray_d,
    input  logic [3*W-1:0] pl_n,
    input  logic [W-1:0]   pl_d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   t,
    output logic           hit
);
    localparam int ACC_W = W + 2;
    localparam int NUM_W = ACC_W + 1;
    localparam int DW    = W + FRAC;

    localparam logic signed [W-1:0]     MAX_W  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     MIN_W  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [NUM_W-1:0] SAT_HI = NUM_W'(MAX_W);
    localparam logic signed [NUM_W-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DOT    = 3'd1,
        CHECK  = 3'd2,
        DSTART = 3'd3,
        DWAIT  = 3'd4,
        OUT    = 3'd5
    } state_t;

    state_t r_state;

    logic [3*W-1:0]           r_ray_o;
    logic [3*W-1:0]           r_ray_d;
    logic [3*W-1:0]           r_pl_n;
    logic signed [W-1:0]      r_pl_d;
    logic [2:0]               r_idx;
    logic signed [ACC_W-1:0]  r_acc_den;
    logic signed [ACC_W-1:0]  r_acc_no;
    logic signed [W-1:0]      r_num;
    logic signed [W-1:0]      r_den;
    logic                     r_div_start;

    logic signed [W-1:0]      w_mul_a;
    logic signed [W-1:0]      w_mul_b;
    logic signed [2*W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [NUM_W-1:0]  w_num_full;
    logic signed [W-1:0]      w_num_sat;
    logic signed [W-1:0]      w_den_sat;
    logic [DW-1:0]            w_dividend;
    logic [DW-1:0]            w_divisor;
    logic [DW-1:0]            w_quot;
    logic                     w_div_done;
    logic                     w_q_ovf;
    logic signed [W-1:0]      w_t_sat;

    // Symmetric saturation keeps -den / -num representable inside the divider.
    function automatic logic signed [W-1:0] sat_sym(input logic signed [NUM_W-1:0] v);
        if (v > SAT_HI)
            sat_sym = MAX_W;
        else if (v < SAT_LO)
            sat_sym = -MAX_W;
        else
            sat_sym = W'(v);
    endfunction

    // Shared multiplier: terms 0..2 build N.D, terms 3..5 build N.O.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_idx)
            3'd0: begin w_mul_a = r_pl_n[W-1:0];     w_mul_b = r_ray_d[W-1:0];     end
            3'd1: begin w_mul_a = r_pl_n[2*W-1:W];   w_mul_b = r_ray_d[2*W-1:W];   end
            3'd2: begin w_mul_a = r_pl_n[3*W-1:2*W]; w_mul_b = r_ray_d[3*W-1:2*W]; end
            3'd3: begin w_mul_a = r_pl_n[W-1:0];     w_mul_b = r_ray_o[W-1:0];     end
            3'd4: begin w_mul_a = r_pl_n[2*W-1:W];   w_mul_b = r_ray_o[2*W-1:W];   end
            3'd5: begin w_mul_a = r_pl_n[3*W-1:2*W]; w_mul_b = r_ray_o[3*W-1:2*W]; end
            default: begin w_mul_a = '0; w_mul_b = '0; end
        endcase
    end

    assign w_prod     = w_mul_a * w_mul_b;
    // Arithmetic shift floors the product; keep the low ACC_W bits.
    assign w_term     = ACC_W'(w_prod >>> FRAC);
    assign w_num_full = NUM_W'(r_pl_d) - NUM_W'(r_acc_no);
    assign w_num_sat  = sat_sym(w_num_full);
    assign w_den_sat  = sat_sym(NUM_W'(r_acc_den));

    assign w_dividend = {r_num, {FRAC{1'b0}}};
    assign w_divisor  = DW'(r_den);

    div #(
        .DWIDTH (DW),
        .FAST   (1)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (r_div_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    // Quotient fits in W bits only if its upper bits are a pure sign extension.
    assign w_q_ovf = !((&w_quot[DW-1:W-1]) || !(|w_quot[DW-1:W-1]));
    assign w_t_sat = w_q_ovf ? (w_quot[DW-1] ? MIN_W : MAX_W) : w_quot[W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            t           <= '0;
            hit         <= 1'b0;
            r_ray_o     <= '0;
            r_ray_d     <= '0;
            r_pl_n      <= '0;
            r_pl_d      <= '0;
            r_idx       <= '0;
            r_acc_den   <= '0;
            r_acc_no    <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_ray_o   <= ray_o;
                        r_ray_d   <= ray_d;
                        r_pl_n    <= pl_n;
                        r_pl_d    <= pl_d;
                        r_idx     <= '0;
                        r_acc_den <= '0;
                        r_acc_no  <= '0;
                        in_ready  <= 1'b0;
                        r_state   <= DOT;
                    end
                end
                DOT: begin
                    if (r_idx < 3'd3)
                        r_acc_den <= r_acc_den + w_term;
                    else
                        r_acc_no  <= r_acc_no + w_term;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == 3'd5)
                        r_state <= CHECK;
                end
                CHECK: begin
                    r_num <= w_num_sat;
                    r_den <= w_den_sat;
                    if (w_den_sat == '0) begin
                        t         <= '0;
                        hit       <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= OUT;
                    end else begin
                        r_div_start <= 1'b1;
                        r_state     <= DSTART;
                    end
                end
                DSTART: begin
                    r_state <= DWAIT;
                end
                DWAIT: begin
                    if (w_div_done) begin
                        t         <= w_t_sat;
                        hit       <= (w_t_sat >= T_MIN);
                        out_valid <= 1'b1;
                        r_state   <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ray_plane_t.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ray_plane_t
//  Purpose  : Self-checking bench for ray_plane_t using a table of directed
//             ray/plane vectors with hand-computed t/hit, plus sequences for
//             output back-pressure and reset during the divide.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ray_plane_t;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] ray_o;
    logic [95:0] ray_d;
    logic [95:0] pl_n;
    logic [31:0] pl_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] t;
    logic        hit;

    ray_plane_t dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ray_o     (ray_o),
        .ray_d     (ray_d),
        .pl_n      (pl_n),
        .pl_d      (pl_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .t         (t),
        .hit       (hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [95:0] o;
        logic [95:0] d;
        logic [95:0] n;
        logic [31:0] pd;
        logic [31:0] et;
        logic        ehit;
        logic        den0;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int n_chk   = 0;
    int n_pass  = 0;
    int start_cnt = 0;

    always @(posedge clock) if (dut.u_div.start) start_cnt++;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic logic [95:0] v3(logic [31:0] z, logic [31:0] y, logic [31:0] x);
        return {z, y, x};
    endfunction

    function automatic vec_t mk(logic [95:0] o, logic [95:0] d, logic [95:0] n,
                                logic [31:0] pd, logic [31:0] et, logic eh, logic d0);
        vec_t v;
        v.o = o; v.d = d; v.n = n; v.pd = pd; v.et = et; v.ehit = eh; v.den0 = d0;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input int hold, input string nm);
        int  n;
        int  lat;
        logic ok;
        @(negedge clock);
        ray_o = v.o; ray_d = v.d; pl_n = v.n; pl_d = v.pd;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clock); n++; end
        chk({nm, " ready_before_accept"}, {31'd0, in_ready}, 32'd1);
        start_cnt = 0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                ray_o = {$urandom, $urandom, $urandom};
                ray_d = {$urandom, $urandom, $urandom};
                pl_n  = {$urandom, $urandom, $urandom};
                pl_d  = $urandom;
                chk({nm, " ready_drop"}, {31'd0, in_ready}, 32'd0);
            end
        end while (!out_valid && lat < 400);
        chk({nm, " out_valid_timeout"}, {31'd0, out_valid}, 32'd1);
        chk({nm, " t"}, t, v.et);
        chk({nm, " hit"}, {31'd0, hit}, {31'd0, v.ehit});
        if (v.den0) begin
            chk({nm, " latency"}, lat, 32'd8);
            chk({nm, " div_starts"}, start_cnt, 32'd0);
        end else begin
            chk({nm, " div_starts"}, start_cnt, 32'd1);
        end
        if (hold > 0) begin
            ok = 1'b1;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                if (!(out_valid && t === v.et && hit === v.ehit && !in_ready)) ok = 1'b0;
            end
            chk({nm, " hold_stable"}, {31'd0, ok}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({nm, " out_valid_clear"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    localparam logic [31:0] ONE = 32'h0001_0000;

    initial begin
        int  lat;
        logic ok;

        vecs[0]  = mk(96'd0, v3(ONE,0,0), v3(ONE,0,0), 32'h0005_0000, 32'h0005_0000, 1'b1, 1'b0);
        vecs[1]  = mk(96'd0, v3(ONE,0,0), v3(32'hFFFF_0000,0,0), 32'h0002_8000, 32'hFFFD_8000, 1'b0, 1'b0);
        vecs[2]  = mk(96'd0, v3(ONE,0,0), v3(32'hFFFF_0000,0,0), 32'hFFFD_8000, 32'h0002_8000, 1'b1, 1'b0);
        vecs[3]  = mk(96'd0, v3(0,0,ONE), v3(ONE,0,0), 32'h0005_0000, 32'h0, 1'b0, 1'b1);
        vecs[4]  = mk(96'd0, v3(32'h1,0,0), v3(ONE,0,0), 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        vecs[5]  = mk(96'd0, v3(ONE,0,0), v3(ONE,0,0), 32'h0, 32'h0, 1'b0, 1'b0);
        vecs[6]  = mk(v3(0,ONE,0), v3(0,32'h0002_0000,0), v3(0,ONE,0), 32'h0004_0000, 32'h0001_8000, 1'b1, 1'b0);
        vecs[7]  = mk(96'd0, v3(0,0,32'h0003_0000), v3(0,0,ONE), ONE, 32'h0000_5555, 1'b1, 1'b0);
        vecs[8]  = mk(96'd0, v3(0,0,ONE), v3(0,0,ONE), 32'h0000_003F, 32'h0000_003F, 1'b0, 1'b0);
        vecs[9]  = mk(96'd0, v3(0,0,ONE), v3(0,0,ONE), 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b0);
        vecs[10] = mk(96'd0, v3(0,0,32'h0003_0000), v3(0,0,ONE), 32'hFFFF_0000, 32'hFFFF_AAAB, 1'b0, 1'b0);
        vecs[11] = mk(96'd0, v3(32'h1,0,0), v3(ONE,0,0), 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        vecs[12] = mk(v3(32'h0003_0000,32'h0002_0000,ONE), v3(ONE,ONE,ONE), v3(ONE,ONE,ONE),
                      32'h000C_0000, 32'h0002_0000, 1'b1, 1'b0);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ray_o = '0; ray_d = '0; pl_n = '0; pl_d = '0;
        repeat (3) @(negedge clock);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset t", t, 32'd0);
        chk("reset hit", {31'd0, hit}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_txn(vecs[i], 0, $sformatf("v%0d", i));

        // Back-pressure: result held 20 cycles while a new request waits.
        run_txn(vecs[0], 20, "hold");
        run_txn(vecs[6], 0, "after_hold");

        // Reset while the divider is iterating.
        @(negedge clock);
        ray_o = vecs[0].o; ray_d = vecs[0].d; pl_n = vecs[0].n; pl_d = vecs[0].pd;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (13) @(negedge clock);
        chk("mid_dwait out_valid", {31'd0, out_valid}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        ok = 1'b1;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clock);
            if (out_valid || !in_ready) ok = 1'b0;
        end
        chk("reset_discard", {31'd0, ok}, 32'd1);
        run_txn(vecs[0], 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
